// File: rtl/bcd_frame_builder_pkg.sv
// bcd_frame_builder_pkg: shared constants, FSM states and display modes for the frame builder
package bcd_frame_builder_pkg;
  localparam int NUM_LEDS = 16;
  typedef enum logic [1:0] {IDLE, BUILD, COMMIT} state_t;
  typedef enum logic [1:0] {MODE_NORMAL, MODE_SET, MODE_RAINBOW} mode_t;
  localparam logic [23:0] WHITE_GRB = 24'hFFFFFF;
  localparam logic [23:0] RED_GRB   = 24'h00FF00;
  localparam logic [23:0] OFF_GRB   = 24'h000000;
endpackage

// File: rtl/bcd_frame_builder_colour_wheel.sv
// colour_wheel: maps an 8-bit hue position to a {G,R,B} colour on a three-segment wheel
//   pos : hue position 0..255
//   grb : {G,R,B}, 8 bits per channel
module colour_wheel (
  input  logic [7:0]  pos,
  output logic [23:0] grb
);
  logic [7:0] seg, up, dn;
  always_comb begin
    seg = pos < 8'd85 ? pos : pos < 8'd170 ? pos - 8'd85 : pos - 8'd170;
    up  = seg * 8'd3;
    dn  = 8'd255 - up;
    grb = pos < 8'd85 ? {8'd0, dn, up} : pos < 8'd170 ? {up, 8'd0, dn} : {dn, up, 8'd0};
  end
endmodule

// File: rtl/bcd_frame_builder.sv
// bcd_frame_builder: snapshots hh:mm BCD digits and builds a 4x4 snake-wired GRB frame for ws2812
//   CLK, reset (async, active-high)
//   frame_tick : one-cycle build request, dropped while busy
//   btn_fast   : time-set indicator, selects red-only rendering
//   dh1..dm0   : BCD hour/minute digits
//   packed_rgb_data : LED i at [24*i +: 24] as {G,R,B}, changes only on commit
//   frame_valid     : one-cycle pulse per committed frame
//   busy            : high while building or committing
//   BCD_FRAME_RAINBOW_EN : when defined, 00:00 and 12:00 render a rotating rainbow
module bcd_frame_builder
  import bcd_frame_builder_pkg::*;
#(
`ifdef BCD_FRAME_RAINBOW_EN
  parameter int WHEEL_STEP = 16,
`endif
  parameter int BRIGHT_SHIFT = 0
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    btn_fast,
  input  logic [3:0]              dh1,
  input  logic [3:0]              dh0,
  input  logic [3:0]              dm1,
  input  logic [3:0]              dm0,
  output logic [24*NUM_LEDS-1:0]  packed_rgb_data,
  output logic                    frame_valid,
  output logic                    busy
);
  state_t state_q, state_d;
  mode_t mode_q, mode_d, mode_now;
  logic [3:0] idx_q, idx_d;
  logic [15:0] bits_q, bits_d, digit_bits;
  logic [24*NUM_LEDS-1:0] shadow_q, shadow_d, packed_q, packed_d;
  logic commit_q, commit_d, valid_q, valid_d;
  logic [23:0] colour, pixel;
`ifdef BCD_FRAME_RAINBOW_EN
  logic [7:0] wheel_pos_q, wheel_pos_d;
  logic [23:0] wheel_grb;
  colour_wheel u_wheel (.pos(wheel_pos_q + 8'(idx_q * WHEEL_STEP)), .grb(wheel_grb));
`endif
  always_comb begin
    // snake wiring: even rows run dh1->dm0, odd rows run dm0->dh1; row r shows digit bit r
    digit_bits = {dh1[3], dh0[3], dm1[3], dm0[3], dm0[2], dm1[2], dh0[2], dh1[2],
                  dh1[1], dh0[1], dm1[1], dm0[1], dm0[0], dm1[0], dh0[0], dh1[0]};
    mode_now = btn_fast ? MODE_SET : MODE_NORMAL;
`ifdef BCD_FRAME_RAINBOW_EN
    if (!btn_fast && ({dh1, dh0, dm1, dm0} == 16'h0000 || {dh1, dh0, dm1, dm0} == 16'h1200))
      mode_now = MODE_RAINBOW;
`endif
    colour =
`ifdef BCD_FRAME_RAINBOW_EN
      mode_q == MODE_RAINBOW ? wheel_grb :
`endif
      !bits_q[idx_q] ? OFF_GRB : mode_q == MODE_SET ? RED_GRB : WHITE_GRB;
    pixel = {colour[23:16] >> BRIGHT_SHIFT, colour[15:8] >> BRIGHT_SHIFT, colour[7:0] >> BRIGHT_SHIFT};
    state_d = state_q;
    mode_d = mode_q;
    idx_d = idx_q;
    bits_d = bits_q;
    shadow_d = shadow_q;
    commit_d = 1'b0;
`ifdef BCD_FRAME_RAINBOW_EN
    wheel_pos_d = wheel_pos_q;
`endif
    case (state_q)
      IDLE: if (frame_tick) begin
        state_d = BUILD;
        mode_d = mode_now;
        bits_d = digit_bits;
        idx_d = 4'd0;
      end
      BUILD: begin
        shadow_d[24*idx_q +: 24] = pixel;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(NUM_LEDS - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        commit_d = 1'b1;
        state_d = IDLE;
`ifdef BCD_FRAME_RAINBOW_EN
        wheel_pos_d = wheel_pos_q + 8'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
    // the copy lands one edge after COMMIT; a new build writing shadow[0] on that edge is harmless
    packed_d = commit_q ? shadow_q : packed_q;
    valid_d = commit_q;
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q <= MODE_NORMAL;
      idx_q <= '0;
      bits_q <= '0;
      shadow_q <= '0;
      packed_q <= '0;
      commit_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef BCD_FRAME_RAINBOW_EN
      wheel_pos_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      idx_q <= idx_d;
      bits_q <= bits_d;
      shadow_q <= shadow_d;
      packed_q <= packed_d;
      commit_q <= commit_d;
      valid_q <= valid_d;
`ifdef BCD_FRAME_RAINBOW_EN
      wheel_pos_q <= wheel_pos_d;
`endif
    end
  end
  assign packed_rgb_data = packed_q;
  assign frame_valid = valid_q;
  assign busy = state_q != IDLE;
endmodule
